// File: rtl/playback_sequencer_pkg.sv
// Shared definitions for the playback sequencer: word layout, widths and
// the sequencer state encoding.
package playback_sequencer_pkg;

  // Memory word layout: [7:5] length code L, [4:0] note code (0 = rest)
  localparam int WORD_WIDTH  = 8;
  localparam int INDEX_WIDTH = 8;
  localparam int NOTE_WIDTH  = 5;
  localparam int NOTE_LSB    = 0;
  localparam int LEN_WIDTH   = 3;
  localparam int LEN_LSB     = 5;

  // Beat counter must hold L+1 = 1..8
  localparam int BEAT_WIDTH  = LEN_WIDTH + 1;
  // Articulation gap counter holds 1..255
  localparam int GAP_WIDTH   = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REWIND = 3'd1,
    ST_FETCH  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_PLAY   = 3'd4,
    ST_GAP    = 3'd5,
    ST_DONE   = 3'd6
  } seq_state_t;

  // Number of beats a note lasts for a given length code (L+1)
  function automatic logic [BEAT_WIDTH-1:0] beats_of(input logic [LEN_WIDTH-1:0] len_code);
    return {1'b0, len_code} + BEAT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/playback_sequencer_note_timer.sv
// Beat counter for the note currently playing. Loads L+1 beats, counts
// down one per beat tick while running and not paused, and flags the tick
// that exhausts the note.
module note_timer
  import playback_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load,
  input  logic [BEAT_WIDTH-1:0] load_value,
  input  logic                  run,
  input  logic                  pause,
  input  logic                  tick,
  output logic                  zero
);

  logic [BEAT_WIDTH-1:0] count_reg;
  logic [BEAT_WIDTH-1:0] count_next;
  logic                  step;

  // A beat is consumed only while running, unpaused, and with beats left
  assign step = run && tick && !pause && (count_reg != '0);
  // Zero flag: this tick takes the counter to zero
  assign zero = step && (count_reg == BEAT_WIDTH'(1));

  // Next-count selection: clear beats load beats decrement
  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (load) begin
      count_next = load_value;
    end else if (step) begin
      count_next = count_reg - BEAT_WIDTH'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/playback_sequencer.sv
// Song playback sequencer: walks song words from the memory unit, plays
// each note for L+1 beats, mutes for a fixed articulation gap, and pulses
// done at the end of the song. All outputs come straight from registers.
module playback_sequencer
  import playback_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH    = WORD_WIDTH,
  parameter int MAX_DEPTH_BIT = INDEX_WIDTH,
  parameter int GAP_CYCLES    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     pause,
  input  logic                     beat_tick,
  input  logic [MAX_DEPTH_BIT-1:0] song_len,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  input  logic                     mem_ready,
  output logic                     mem_read_en,
  output logic                     mem_read_rst,
  output logic [NOTE_WIDTH-1:0]    note_out,
  output logic                     note_valid,
  output logic [MAX_DEPTH_BIT-1:0] note_index,
  output logic                     busy,
  output logic                     done
);

  seq_state_t                 state_reg, state_next;
  logic [MAX_DEPTH_BIT-1:0]   len_reg, len_next;
  logic [MAX_DEPTH_BIT-1:0]   index_reg, index_next;
  logic [NOTE_WIDTH-1:0]      note_reg, note_next;
  logic                       valid_reg, valid_next;
  logic [GAP_WIDTH-1:0]       gap_reg, gap_next;
  logic                       rd_reg, rd_next;
  logic                       rrst_reg, rrst_next;
  logic                       busy_reg, busy_next;
  logic                       done_reg, done_next;

  logic                       timer_load;
  logic                       timer_clear;
  logic                       timer_zero;
  logic [NOTE_WIDTH-1:0]      word_note;
  logic [BEAT_WIDTH-1:0]      word_beats;

  assign word_note  = mem_data[NOTE_LSB +: NOTE_WIDTH];
  assign word_beats = beats_of(mem_data[LEN_LSB +: LEN_WIDTH]);

  note_timer u_note_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (timer_clear),
    .load       (timer_load),
    .load_value (word_beats),
    .run        (state_reg == ST_PLAY),
    .pause      (pause),
    .tick       (beat_tick),
    .zero       (timer_zero)
  );

  // Next-state and next-output logic; stop overrides everything outside IDLE
  always_comb begin
    state_next  = state_reg;
    len_next    = len_reg;
    index_next  = index_reg;
    note_next   = note_reg;
    valid_next  = valid_reg;
    gap_next    = gap_reg;
    rd_next     = 1'b0;
    rrst_next   = 1'b0;
    done_next   = 1'b0;
    timer_load  = 1'b0;
    timer_clear = 1'b0;

    if (stop && (state_reg != ST_IDLE)) begin
      state_next  = ST_IDLE;
      index_next  = '0;
      note_next   = '0;
      valid_next  = 1'b0;
      gap_next    = '0;
      rrst_next   = 1'b1;
      timer_clear = 1'b1;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (start && !stop) begin
            if (song_len != '0) begin
              state_next = ST_REWIND;
              len_next   = song_len;
              index_next = '0;
              rrst_next  = 1'b1;
            end else begin
              // Empty song finishes immediately without leaving IDLE
              done_next = 1'b1;
            end
          end
        end
        ST_REWIND: begin
          state_next = ST_FETCH;
          rd_next    = 1'b1;
        end
        ST_FETCH: begin
          state_next = ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_ready) begin
            state_next = ST_PLAY;
            note_next  = word_note;
            valid_next = (word_note != '0);
            timer_load = 1'b1;
          end
        end
        ST_PLAY: begin
          if (timer_zero) begin
            state_next = ST_GAP;
            valid_next = 1'b0;
            gap_next   = GAP_WIDTH'(GAP_CYCLES);
          end else begin
            // Pause mutes the tone; release restores it for audible notes
            valid_next = !pause && (note_reg != '0);
          end
        end
        ST_GAP: begin
          if (gap_reg == GAP_WIDTH'(1)) begin
            if ((index_reg + MAX_DEPTH_BIT'(1)) == len_reg) begin
              state_next = ST_DONE;
              done_next  = 1'b1;
              note_next  = '0;
            end else begin
              state_next = ST_FETCH;
              index_next = index_reg + MAX_DEPTH_BIT'(1);
              rd_next    = 1'b1;
            end
          end else begin
            gap_next = gap_reg - GAP_WIDTH'(1);
          end
        end
        ST_DONE: begin
          state_next = ST_IDLE;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end

    busy_next = (state_next != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      len_reg   <= '0;
      index_reg <= '0;
      note_reg  <= '0;
      valid_reg <= 1'b0;
      gap_reg   <= '0;
      rd_reg    <= 1'b0;
      rrst_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      index_reg <= index_next;
      note_reg  <= note_next;
      valid_reg <= valid_next;
      gap_reg   <= gap_next;
      rd_reg    <= rd_next;
      rrst_reg  <= rrst_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign mem_read_en  = rd_reg;
  assign mem_read_rst = rrst_reg;
  assign note_out     = note_reg;
  assign note_valid   = valid_reg;
  assign note_index   = index_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_playback_sequencer.sv
// Bench for playback_sequencer: a behavioural song-player model plus a
// memory-unit emulator, directed scenarios and randomized playback.
module tb_playback_sequencer;

  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       beat_tick = 1'b0;
  logic [7:0] song_len = 8'd0;
  logic [7:0] mem_data = 8'd0;
  logic       mem_ready = 1'b0;
  logic       mem_read_en, mem_read_rst;
  logic [4:0] note_out;
  logic       note_valid;
  logic [7:0] note_index;
  logic       busy, done;

  always #5 clk = ~clk;

  playback_sequencer #(
    .DATA_WIDTH(8), .MAX_DEPTH_BIT(8), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .beat_tick(beat_tick), .song_len(song_len), .mem_data(mem_data),
    .mem_ready(mem_ready), .mem_read_en(mem_read_en),
    .mem_read_rst(mem_read_rst), .note_out(note_out),
    .note_valid(note_valid), .note_index(note_index), .busy(busy), .done(done)
  );

  int tests = 0;
  int fails = 0;

  // Memory unit emulator
  logic [7:0] song_mem [0:255];
  logic [7:0] resp_word = 8'd0;
  int  rd_ptr = 0;
  int  pend = 0;
  int  fixed_delay = 1;
  bit  keep_pending = 0;
  int  tick_mode = 0;  // 0 manual, 1 random, 2 every cycle

  // Behavioural player model: what the outputs must show this cycle
  typedef enum int {M_IDLE, M_REWIND, M_FETCH, M_WAIT, M_PLAY, M_GAP, M_DONE} mphase_t;
  mphase_t    ph = M_IDLE;
  int         beats_left = 0, gap_left = 0, m_len = 0, e_idx = 0;
  logic [4:0] e_note = 5'd0;
  bit         e_valid = 0, e_busy = 0, e_done = 0, e_rd = 0, e_rrst = 0;

  // Observation statistics
  int  n_done, n_busy, n_rd, n_rrst, n_eff_ticks, n_valid, cur_ticks;
  int  note_ticks[$];
  int  notes_seen[$];
  int  idx_seen[$];
  bit  prev_valid = 0;

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic clear_stats();
    n_done = 0; n_busy = 0; n_rd = 0; n_rrst = 0; n_eff_ticks = 0;
    n_valid = 0; cur_ticks = 0;
    note_ticks.delete(); notes_seen.delete(); idx_seen.delete();
  endtask

  task automatic check_lit(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Advance the model by one clock using the inputs the DUT just sampled
  task automatic model_step();
    e_done = 0; e_rd = 0; e_rrst = 0;
    if (rst) begin
      ph = M_IDLE; e_note = 0; e_valid = 0; e_idx = 0; e_busy = 0;
      m_len = 0; beats_left = 0; gap_left = 0;
    end else if (stop && ph != M_IDLE) begin
      ph = M_IDLE; e_note = 0; e_valid = 0; e_idx = 0; e_busy = 0; e_rrst = 1;
    end else begin
      case (ph)
        M_IDLE: if (start && !stop) begin
          if (song_len != 0) begin
            ph = M_REWIND; m_len = int'(song_len); e_idx = 0; e_rrst = 1; e_busy = 1;
          end else e_done = 1;
        end
        M_REWIND: begin ph = M_FETCH; e_rd = 1; end
        M_FETCH:  ph = M_WAIT;
        M_WAIT: if (mem_ready) begin
          e_note = mem_data[4:0];
          beats_left = int'(mem_data[7:5]) + 1;
          e_valid = (e_note != 0);
          ph = M_PLAY;
        end
        M_PLAY: begin
          if (pause) e_valid = 0;
          else begin
            e_valid = (e_note != 0);
            if (beat_tick) begin
              beats_left--;
              if (beats_left == 0) begin e_valid = 0; ph = M_GAP; gap_left = GAP; end
            end
          end
        end
        M_GAP: begin
          gap_left--;
          if (gap_left == 0) begin
            if (e_idx + 1 == m_len) begin ph = M_DONE; e_done = 1; e_note = 0; end
            else begin e_idx++; ph = M_FETCH; e_rd = 1; end
          end
        end
        M_DONE: begin ph = M_IDLE; e_busy = 0; end
        default: ph = M_IDLE;
      endcase
    end
  endtask

  task automatic mem_emulate();
    mem_ready = 0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin mem_ready = 1; mem_data = resp_word; end
    end
    if (mem_read_rst) begin
      rd_ptr = 0;
      if (!keep_pending) begin pend = 0; mem_ready = 0; end
    end
    if (mem_read_en) begin
      resp_word = song_mem[rd_ptr[7:0]];
      rd_ptr++;
      pend = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 4));
    end
  endtask

  task automatic take_stats();
    n_done += int'(done); n_busy += int'(busy); n_rd += int'(mem_read_en);
    n_rrst += int'(mem_read_rst); n_valid += int'(note_valid);
    if (note_valid && !pause && beat_tick) begin n_eff_ticks++; cur_ticks++; end
    if (note_valid && !prev_valid) begin
      notes_seen.push_back(int'(note_out)); idx_seen.push_back(int'(note_index));
    end
    if (!note_valid && prev_valid) begin note_ticks.push_back(cur_ticks); cur_ticks = 0; end
    prev_valid = note_valid;
  endtask

  // Compare every DUT output with the model
  task automatic check_outputs();
    tests++;
    if ((mem_read_en !== e_rd) || (mem_read_rst !== e_rrst) || (note_out !== e_note) ||
        (note_valid !== e_valid) || (note_index !== 8'(e_idx)) || (busy !== e_busy) ||
        (done !== e_done)) begin
      fails++;
      $display("FAIL outputs @%0t: got rd=%0b rrst=%0b note=%0d valid=%0b idx=%0d busy=%0b done=%0b, expected rd=%0b rrst=%0b note=%0d valid=%0b idx=%0d busy=%0b done=%0b",
               $time, mem_read_en, mem_read_rst, note_out, note_valid, note_index, busy, done,
               e_rd, e_rrst, e_note, e_valid, e_idx, e_busy, e_done);
    end
  endtask

  // One clock: log the ending cycle, step model, drive, then compare
  task automatic cyc();
    take_stats();
    @(posedge clk);
    #1;
    model_step();
    start = 0; stop = 0;
    beat_tick = (tick_mode == 2) ? 1'b1 : (tick_mode == 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
    mem_emulate();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_until_idle(input string name, input int max);
    int n = 0;
    do begin cyc(); n++; end while ((busy || n < 2) && n < max);
    tests++;
    if (busy) begin fails++; $display("FAIL %s timeout: busy=%0b after %0d cycles, expected idle", name, busy, n); end
  endtask

  task automatic wait_valid(input string name, input int max);
    int n = 0;
    while (!note_valid && n < max) begin cyc(); n++; end
    tests++;
    if (!note_valid) begin fails++; $display("FAIL %s timeout: note_valid=%0b, expected 1", name, note_valid); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) song_mem[i] = 8'h00;
    clear_stats();

    // Reset state
    rst = 1;
    repeat (3) cyc();
    check_lit("reset_busy", int'(busy), 0);
    check_lit("reset_valid", int'(note_valid), 0);
    check_lit("reset_read_en", int'(mem_read_en), 0);
    rst = 0;
    cyc();

    // Three-note song, memory answers one cycle after each request
    song_mem[0] = 8'h25; song_mem[1] = 8'h05; song_mem[2] = 8'h4A;
    song_len = 8'd3; fixed_delay = 1; tick_mode = 1;
    clear_stats();
    start = 1;
    run_until_idle("song3", 1000);
    check_lit("song3_done_count", n_done, 1);
    check_lit("song3_note_count", notes_seen.size(), 3);
    check_lit("song3_note0", qget(notes_seen, 0), 5);
    check_lit("song3_note1", qget(notes_seen, 1), 5);
    check_lit("song3_note2", qget(notes_seen, 2), 10);
    check_lit("song3_idx0", qget(idx_seen, 0), 0);
    check_lit("song3_idx1", qget(idx_seen, 1), 1);
    check_lit("song3_idx2", qget(idx_seen, 2), 2);
    check_lit("song3_ticks0", qget(note_ticks, 0), 2);
    check_lit("song3_ticks1", qget(note_ticks, 1), 1);
    check_lit("song3_ticks2", qget(note_ticks, 2), 3);

    // Empty song: done next cycle, never busy, never fetches
    song_len = 8'd0; tick_mode = 0;
    clear_stats();
    start = 1;
    cyc();
    check_lit("len0_done_next", int'(done), 1);
    repeat (3) cyc();
    check_lit("len0_done_count", n_done, 1);
    check_lit("len0_busy_cycles", n_busy, 0);
    check_lit("len0_read_en", n_rd, 0);

    // Rest word with L=7 and a tick every cycle: done lands 16 cycles on
    song_mem[0] = 8'hE0; song_len = 8'd1; tick_mode = 2;
    clear_stats();
    start = 1;
    begin
      int k = 0, done_at = -1;
      while (done_at < 0 && k < 100) begin
        cyc(); k++;
        if (done) done_at = k;
      end
      check_lit("rest_done_cycle", done_at, 16);
    end
    run_until_idle("rest", 50);
    check_lit("rest_valid_cycles", n_valid, 0);
    tick_mode = 0;

    // Pause during the second tick of a three-beat note
    song_mem[0] = 8'h47; song_len = 8'd1; fixed_delay = 1;
    clear_stats();
    start = 1;
    wait_valid("pause_play", 20);
    cyc();
    beat_tick = 1; cyc();
    cyc();
    pause = 1; beat_tick = 1; cyc();
    check_lit("pause_mute", int'(note_valid), 0);
    for (int t = 0; t < 5; t++) begin beat_tick = 1; cyc(); cyc(); end
    check_lit("pause_hold", int'(note_valid), 0);
    pause = 0; cyc();
    check_lit("pause_release", int'(note_valid), 1);
    cyc();
    beat_tick = 1; cyc();
    cyc();
    check_lit("pause_still_playing", int'(note_valid), 1);
    beat_tick = 1; cyc();
    check_lit("pause_note_end", int'(note_valid), 0);
    run_until_idle("pause", 50);
    check_lit("pause_eff_ticks", n_eff_ticks, 3);
    check_lit("pause_done_count", n_done, 1);

    // Stop while waiting on a slow memory; the late answer must be ignored
    song_mem[0] = 8'h25; song_len = 8'd1; fixed_delay = 10; keep_pending = 1;
    clear_stats();
    start = 1;
    repeat (6) cyc();
    stop = 1; cyc();
    check_lit("stop_busy", int'(busy), 0);
    check_lit("stop_rewind", int'(mem_read_rst), 1);
    repeat (12) cyc();
    check_lit("stop_done_count", n_done, 0);
    check_lit("stop_rewind_count", n_rrst, 2);
    check_lit("stop_late_valid", n_valid, 0);
    keep_pending = 0; fixed_delay = 1;

    // Reset in PLAY, then replay from the first word
    song_mem[0] = 8'h25; song_mem[1] = 8'h4A; song_len = 8'd2; tick_mode = 0;
    start = 1;
    wait_valid("rst_play", 20);
    rst = 1; cyc(); rst = 0;
    check_lit("rst_mid_valid", int'(note_valid), 0);
    check_lit("rst_mid_busy", int'(busy), 0);
    check_lit("rst_mid_rewind", int'(mem_read_rst), 0);
    check_lit("rst_mid_note", int'(note_out), 0);
    cyc();
    clear_stats(); tick_mode = 1;
    start = 1;
    run_until_idle("replay", 1000);
    check_lit("replay_idx0", qget(idx_seen, 0), 0);
    check_lit("replay_idx1", qget(idx_seen, 1), 1);
    check_lit("replay_note0", qget(notes_seen, 0), 5);
    check_lit("replay_note1", qget(notes_seen, 1), 10);
    check_lit("replay_done_count", n_done, 1);

    // Randomized songs with random pause, stop, restart and reset
    for (int it = 0; it < 40; it++) begin
      int len, c;
      len = $urandom_range(1, 5);
      for (int w = 0; w < len; w++) song_mem[w] = 8'($urandom);
      song_len = 8'(len); fixed_delay = 0; tick_mode = 1; pause = 0;
      if ($urandom_range(0, 7) == 0) stop = 1;
      start = 1;
      c = 0;
      while (c < 2000) begin
        cyc(); rst = 0; c++;
        if (!busy && c > 2) break;
        if ($urandom_range(0, 9) == 0) pause = ~pause;
        if (busy) begin
          if ($urandom_range(0, 199) == 0) stop = 1;
          if ($urandom_range(0, 59) == 0) start = 1;
          if ($urandom_range(0, 399) == 0) rst = 1;
          song_len = 8'($urandom);
        end
      end
      tests++;
      if (busy) begin fails++; $display("FAIL random_%0d timeout: busy=%0b, expected idle", it, busy); end
      pause = 0;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/playback_sequencer.md
PLAYBACK_SEQUENCER -- requirements
Module: playback_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, 8, memory word width: bits [7:5] length code L, bits [4:0] note code (0 = rest).
REQ-002 Parameter MAX_DEPTH_BIT, 8, width of song length and note index.
REQ-003 Parameter GAP_CYCLES, 4, articulation gap (note muted) after each note, in clk cycles, legal range 1..255.
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle pulse, begin playback from first word.
REQ-007 stop  in  1  one-cycle pulse, abort playback.
REQ-008 pause  in  1  level, freezes note timing while high.
REQ-009 beat_tick  in  1  one-cycle tempo pulse from external divider.
REQ-010 song_len  in  MAX_DEPTH_BIT  number of words in the song, sampled on start.
REQ-011 mem_data  in  DATA_WIDTH  word from memory unit.
REQ-012 mem_ready  in  1  mem_data valid this cycle.
REQ-013 mem_read_en  out  1  fetch request to memory unit.
REQ-014 mem_read_rst  out  1  rewind memory read pointer.
REQ-015 note_out  out  5  current note code to tone generator.
REQ-016 note_valid  out  1  tone generator enabled.
REQ-017 note_index  out  MAX_DEPTH_BIT  index of current word.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse at normal end of song.

Function
REQ-020 FSM states: IDLE, REWIND, FETCH, WAIT, PLAY, GAP, DONE; all outputs registered.
REQ-021 IDLE: start with song_len!=0 -> REWIND, latch song_len, note_index=0; start with song_len==0 -> done pulse next cycle, stay IDLE.
REQ-022 REWIND: mem_read_rst=1 for exactly one cycle -> FETCH.
REQ-023 FETCH: mem_read_en=1 for exactly one cycle -> WAIT; never two requests outstanding.
REQ-024 WAIT: on mem_ready latch word, note_out=note code, beat counter=L+1, note_valid=1 unless note code 0 -> PLAY; wait unbounded otherwise.
REQ-025 PLAY: each beat_tick with pause low decrements counter; tick bringing counter to 0 -> GAP with note_valid=0.
REQ-026 PLAY with pause high: counter frozen, beat_tick ignored, note_valid=0; pause falling restores note_valid (if note code !=0) next cycle.
REQ-027 pause has no effect in REWIND, FETCH, WAIT, GAP.
REQ-028 GAP: note_valid=0 for GAP_CYCLES cycles; then note_index+1==song_len -> DONE, else note_index increments -> FETCH.
REQ-029 DONE: done=1 one cycle, note_out=0 -> IDLE.
REQ-030 stop in any non-IDLE state: next cycle IDLE, note_valid=0, note_out=0, note_index=0, mem_read_rst=1 one cycle, no done pulse.
REQ-031 stop and start same cycle: stop wins, start ignored; start while busy ignored.
REQ-032 beat_tick arriving same cycle as mem_ready: ignored (counter loads, not decrements).
REQ-033 Note duration in PLAY = exactly L+1 beat_ticks, 1..8 beats.

Reset
REQ-034 rst high: state IDLE, all outputs 0, counters 0, latched song_len 0; reset mid-playback aborts without done or mem_read_rst.

Structure
REQ-035 DATA_WIDTH, MAX_DEPTH_BIT, state encodings, field positions of L and note code reside in shared MemoryPara.v.
REQ-036 One sub-module note_timer (beat counter with load, pause, tick, zero flag) instantiated once; FSM in top.

Verification
REQ-037 song_len=3, words 8'h25, 8'h05, 8'h4A, mem_ready 1 cycle after request -> note 5 for 2 ticks, 5 for 1 tick, 10 for 3 ticks, gaps 4 cycles, single done, note_index 0,1,2.
REQ-038 start with song_len=0 -> done pulse next cycle, busy never high, mem_read_en never high.
REQ-039 word 8'hE0 (rest, L=7) -> note_valid low throughout, PLAY exits after 8 ticks.
REQ-040 pause high during 2nd tick of 3-beat note, 5 ticks while paused -> note_valid 0, counter held, note ends 1 tick after pause release plus remaining ticks.
REQ-041 stop in WAIT with mem_ready delayed 10 cycles -> IDLE next cycle, mem_read_rst pulse, late mem_ready ignored, no done.
REQ-042 rst asserted in PLAY -> all outputs 0 next cycle, subsequent start replays from index 0.
